// File: rtl/vidc_pixel_unpacker.sv
// rtl/vidc_pixel_unpacker.sv - video DMA word FIFO and 1/2/4/8 bpp pixel serialiser
module vidc_pixel_unpacker #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_dma,
    input  logic [31:0]           load_dma_data,
    input  logic                  frame_restart,
    input  logic [1:0]            bpp_sel,
    input  logic                  pix_ready,
    output logic                  pix_valid,
    output logic [7:0]            pix_data,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_flags
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        S_EMPTY,
        S_ACTIVE
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [31:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2:0]   r_wptr;
    logic [DEPTH_LOG2:0]   r_rptr;
    logic [31:0]           r_word;
    logic [1:0]            r_bpp;
    logic [4:0]            r_idx;
    logic                  r_armed;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [DEPTH_LOG2:0]   w_level;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_pop;
    logic                  w_last;
    logic                  w_ovf_evt;
    logic                  w_unf_evt;
    logic [31:0]           w_head;
    logic [DEPTH_LOG2-1:0] w_waddr;
    logic [7:0]            w_pix;

    assign w_level   = r_wptr - r_rptr;
    assign w_empty   = (w_level == '0);
    assign w_full    = (w_level == (DEPTH_LOG2+1)'(DEPTH));
    assign w_head    = r_mem[r_rptr[DEPTH_LOG2-1:0]];
    // A flush rewinds the pointers first, so a coincident word always has room.
    assign w_wr      = load_dma && (frame_restart || !w_full);
    assign w_waddr   = frame_restart ? '0 : r_wptr[DEPTH_LOG2-1:0];
    assign w_last    = (r_idx == (5'd31 >> r_bpp));
    assign w_ovf_evt = load_dma && w_full && !frame_restart;
    assign w_unf_evt = r_armed && pix_ready && !pix_valid;

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (pix_ready && w_last) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_next_state = S_EMPTY;
                    end
                end
            end
            default: w_next_state = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else if (frame_restart) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_waddr] <= load_dma_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_word      <= '0;
            r_bpp       <= '0;
            r_idx       <= '0;
            r_armed     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (frame_restart) begin
                r_rptr  <= '0;
                r_wptr  <= {{DEPTH_LOG2{1'b0}}, load_dma};
                r_idx   <= '0;
                r_armed <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr  <= r_rptr + 1'b1;
                    r_word  <= w_head;
                    r_bpp   <= bpp_sel;
                    r_idx   <= '0;
                    r_armed <= 1'b1;
                end else if (r_state == S_ACTIVE && pix_ready) begin
                    r_idx <= w_last ? 5'd0 : r_idx + 5'd1;
                end
            end
            r_overflow  <= w_ovf_evt || (r_overflow && !clear_flags);
            r_underflow <= w_unf_evt || (r_underflow && !clear_flags);
        end
    end

    // Pixels leave LSB first; the index is scaled by the latched pixel width.
    always_comb begin
        w_pix = 8'd0;
        case (r_bpp)
            2'd0: w_pix = {7'd0, r_word[r_idx]};
            2'd1: w_pix = {6'd0, r_word[{r_idx[3:0], 1'b0} +: 2]};
            2'd2: w_pix = {4'd0, r_word[{r_idx[2:0], 2'b00} +: 4]};
            default: w_pix = r_word[{r_idx[1:0], 3'b000} +: 8];
        endcase
    end

    assign pix_valid  = (r_state == S_ACTIVE);
    assign pix_data   = pix_valid ? w_pix : 8'd0;
    assign fifo_level = w_level;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_vidc_pixel_unpacker.sv
// tb/tb_vidc_pixel_unpacker.sv - directed self-checking bench for vidc_pixel_unpacker
module tb_vidc_pixel_unpacker;

    logic        clk;
    logic        reset;
    logic        load_dma;
    logic [31:0] load_dma_data;
    logic        frame_restart;
    logic [1:0]  bpp_sel;
    logic        pix_ready;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        underflow;
    logic        clear_flags;

    int vectors;
    int miscompares;

    vidc_pixel_unpacker #(.DEPTH_LOG2(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_dma      (load_dma),
        .load_dma_data (load_dma_data),
        .frame_restart (frame_restart),
        .bpp_sel       (bpp_sel),
        .pix_ready     (pix_ready),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .underflow     (underflow),
        .clear_flags   (clear_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_and_clear();
        pix_ready     = 1'b0;
        load_dma      = 1'b0;
        frame_restart = 1'b1;
        clear_flags   = 1'b1;
        step();
        frame_restart = 1'b0;
        clear_flags   = 1'b0;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        clk           = 1'b0;
        reset         = 1'b1;
        load_dma      = 1'b0;
        load_dma_data = 32'd0;
        frame_restart = 1'b0;
        bpp_sel       = 2'd0;
        pix_ready     = 1'b0;
        clear_flags   = 1'b0;

        #12;
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_data", 32'(pix_data), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        reset = 1'b0;

        // 8bpp single word, then starvation
        bpp_sel       = 2'd3;
        pix_ready     = 1'b1;
        load_dma      = 1'b1;
        load_dma_data = 32'h44332211;
        step();
        load_dma = 1'b0;
        check("t1_level_after_load", 32'(fifo_level), 32'd1);
        check("t1_valid_load_cycle", 32'(pix_valid), 32'd0);
        check("t1_unf_unarmed", 32'(underflow), 32'd0);
        step();
        check("t1_valid_first", 32'(pix_valid), 32'd1);
        check("t1_px0", 32'(pix_data), 32'h11);
        check("t1_level_popped", 32'(fifo_level), 32'd0);
        step();
        check("t1_px1", 32'(pix_data), 32'h22);
        step();
        check("t1_px2", 32'(pix_data), 32'h33);
        step();
        check("t1_px3", 32'(pix_data), 32'h44);
        step();
        check("t1_valid_end", 32'(pix_valid), 32'd0);
        check("t1_unf_not_yet", 32'(underflow), 32'd0);
        step();
        check("t1_unf_set", 32'(underflow), 32'd1);
        flush_and_clear();
        check("t1_flags_cleared", 32'(underflow), 32'd0);

        // 1bpp two words back to back
        bpp_sel       = 2'd0;
        pix_ready     = 1'b1;
        load_dma      = 1'b1;
        load_dma_data = 32'h00000005;
        step();
        load_dma_data = 32'hFFFFFFFF;
        step();
        load_dma = 1'b0;
        check("t2_level_1", 32'(fifo_level), 32'd1);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("t2_w0_v%0d", i), 32'(pix_valid), 32'd1);
            check($sformatf("t2_w0_px%0d", i), 32'(pix_data), (32'h5 >> i) & 32'd1);
            step();
        end
        check("t2_level_0", 32'(fifo_level), 32'd0);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("t2_w1_v%0d", i), 32'(pix_valid), 32'd1);
            check($sformatf("t2_w1_px%0d", i), 32'(pix_data), 32'd1);
            step();
        end
        pix_ready = 1'b0;
        check("t2_valid_end", 32'(pix_valid), 32'd0);
        flush_and_clear();

        // fill to full, overflow, clear-vs-event priority, drain
        bpp_sel   = 2'd3;
        pix_ready = 1'b0;
        load_dma  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            load_dma_data = 32'h01010101 * (i + 1);
            step();
        end
        check("t3_level_full", 32'(fifo_level), 32'd16);
        check("t3_ovf_before", 32'(overflow), 32'd0);
        load_dma_data = 32'hEEEEEEEE;
        step();
        check("t3_ovf_set", 32'(overflow), 32'd1);
        check("t3_level_kept", 32'(fifo_level), 32'd16);
        clear_flags = 1'b1;
        step();
        check("t3_ovf_event_wins", 32'(overflow), 32'd1);
        load_dma = 1'b0;
        step();
        clear_flags = 1'b0;
        check("t3_ovf_cleared", 32'(overflow), 32'd0);
        pix_ready = 1'b1;
        for (int w = 0; w < 17; w++) begin
            for (int b = 0; b < 4; b++) begin
                check($sformatf("t3_w%0d_v%0d", w, b), 32'(pix_valid), 32'd1);
                check($sformatf("t3_w%0d_px%0d", w, b), 32'(pix_data), 32'(w + 1));
                step();
            end
        end
        pix_ready = 1'b0;
        check("t3_drained_valid", 32'(pix_valid), 32'd0);
        check("t3_drained_level", 32'(fifo_level), 32'd0);
        flush_and_clear();

        // 4bpp with mid-word bpp change
        bpp_sel       = 2'd2;
        load_dma      = 1'b1;
        load_dma_data = 32'h87654321;
        step();
        load_dma_data = 32'hA1B2C3D4;
        step();
        load_dma  = 1'b0;
        pix_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) bpp_sel = 2'd3;
            check($sformatf("t4_nib%0d", i), 32'(pix_data), 32'(i + 1));
            step();
        end
        check("t4_b0", 32'(pix_data), 32'hD4);
        step();
        check("t4_b1", 32'(pix_data), 32'hC3);
        step();
        check("t4_b2", 32'(pix_data), 32'hB2);
        step();
        check("t4_b3", 32'(pix_data), 32'hA1);
        flush_and_clear();

        // frame_restart coinciding with a DMA word
        bpp_sel  = 2'd3;
        load_dma = 1'b1;
        for (int i = 0; i < 6; i++) begin
            load_dma_data = 32'h11111111 * (i + 1);
            step();
        end
        load_dma = 1'b0;
        check("t5_level_5", 32'(fifo_level), 32'd5);
        check("t5_valid_before", 32'(pix_valid), 32'd1);
        frame_restart = 1'b1;
        load_dma      = 1'b1;
        load_dma_data = 32'hAABBCCDD;
        step();
        frame_restart = 1'b0;
        load_dma      = 1'b0;
        check("t5_level_1", 32'(fifo_level), 32'd1);
        check("t5_valid_flushed", 32'(pix_valid), 32'd0);
        pix_ready = 1'b1;
        step();
        check("t5_unf_before_load", 32'(underflow), 32'd0);
        check("t5_px0", 32'(pix_data), 32'hDD);
        step();
        check("t5_px1", 32'(pix_data), 32'hCC);
        step();
        check("t5_px2", 32'(pix_data), 32'hBB);
        step();
        check("t5_px3", 32'(pix_data), 32'hAA);
        step();
        check("t5_valid_end", 32'(pix_valid), 32'd0);
        step();
        check("t5_unf_set", 32'(underflow), 32'd1);
        pix_ready = 1'b0;

        // asynchronous reset mid-word
        load_dma      = 1'b1;
        load_dma_data = 32'h12345678;
        step();
        load_dma_data = 32'h9ABCDEF0;
        step();
        load_dma = 1'b0;
        check("t6_valid_pre", 32'(pix_valid), 32'd1);
        check("t6_px_pre", 32'(pix_data), 32'h78);
        check("t6_level_pre", 32'(fifo_level), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("t6_valid_async", 32'(pix_valid), 32'd0);
        check("t6_data_async", 32'(pix_data), 32'd0);
        check("t6_level_async", 32'(fifo_level), 32'd0);
        check("t6_unf_async", 32'(underflow), 32'd0);
        check("t6_ovf_async", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("t6_valid_after", 32'(pix_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
